mem_wb_stage: RTL and testbench

Memory-to-writeback pipeline stage of the RV32I pipelined core. Registers the MEM-stage result, aligns and sign/zero-extends load data, selects the writeback source, and drives the register file's write port (`WRITE`, `WRITE_REG`, `WRITE_DATA`). Because the register file samples writes at a posedge and commits them at the following negedge, this stage also keeps a two-deep write history. It exposes that history as a bypass lookup for the decode stage, and counts retired instructions.

---
 rtl/mem_wb_stage_if.sv | 43 ++++
 rtl/mem_wb_stage.sv | 148 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bus: MEM-stage inputs, stall/flush controls, register-file write port,
// decode-stage bypass lookup and retire count. The stage itself uses the slave modport.
interface mem_wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             MEM_VALID;
    logic             MEM_REG_WRITE;
    logic [4:0]       MEM_RD;
    logic [1:0]       MEM_WB_SEL;
    logic [2:0]       MEM_FUNCT3;
    logic [XLEN-1:0]  MEM_ALU_RESULT;
    logic [XLEN-1:0]  MEM_LOAD_DATA;
    logic [XLEN-1:0]  MEM_PC_PLUS4;
    logic             STALL;
    logic             FLUSH;
    logic             WRITE;
    logic [4:0]       WRITE_REG;
    logic [XLEN-1:0]  WRITE_DATA;
    logic [4:0]       FWD_RS1;
    logic [4:0]       FWD_RS2;
    logic             FWD_RS1_HIT;
    logic             FWD_RS2_HIT;
    logic [XLEN-1:0]  FWD_RS1_DATA;
    logic [XLEN-1:0]  FWD_RS2_DATA;
    logic [CNT_W-1:0] RETIRE_COUNT;

    modport master (
        output MEM_VALID, MEM_REG_WRITE, MEM_RD, MEM_WB_SEL, MEM_FUNCT3,
               MEM_ALU_RESULT, MEM_LOAD_DATA, MEM_PC_PLUS4, STALL, FLUSH,
               FWD_RS1, FWD_RS2,
        input  WRITE, WRITE_REG, WRITE_DATA, FWD_RS1_HIT, FWD_RS2_HIT,
               FWD_RS1_DATA, FWD_RS2_DATA, RETIRE_COUNT
    );

    modport slave (
        input  MEM_VALID, MEM_REG_WRITE, MEM_RD, MEM_WB_SEL, MEM_FUNCT3,
               MEM_ALU_RESULT, MEM_LOAD_DATA, MEM_PC_PLUS4, STALL, FLUSH,
               FWD_RS1, FWD_RS2,
        output WRITE, WRITE_REG, WRITE_DATA, FWD_RS1_HIT, FWD_RS2_HIT,
               FWD_RS1_DATA, FWD_RS2_DATA, RETIRE_COUNT
    );
endinterface

// File: rtl/mem_wb_stage.sv
// RV32I MEM->WB stage: load alignment/extension, writeback select, one-shot register-file
// write, retire counter. Define WB_BYPASS_EN to build the write-history bypass lookup.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input logic            CLK,
    input logic            RST_N,
    mem_wb_stage_if.slave  bus
);

    function automatic logic [XLEN-1:0] load_extend(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    logic             r_valid;
    logic             r_reg_write;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_result;
    logic             r_done;
    logic [CNT_W-1:0] r_retire_cnt;

    logic [XLEN-1:0]  w_result;
    logic             w_write;
    logic             w_retire;

    always_comb begin
        w_result = bus.MEM_ALU_RESULT;
        case (bus.MEM_WB_SEL)
            2'b01:   w_result = load_extend(bus.MEM_FUNCT3, bus.MEM_ALU_RESULT[1:0], bus.MEM_LOAD_DATA);
            2'b10:   w_result = bus.MEM_PC_PLUS4;
            default: w_result = bus.MEM_ALU_RESULT;
        endcase
    end

    // done marks an entry already written/retired so a stall cannot repeat it
    assign w_write  = r_valid & r_reg_write & (r_rd != 5'd0) & ~r_done;
    assign w_retire = r_valid & ~r_done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_result     <= '0;
            r_done       <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, w_retire};
            if (bus.FLUSH) begin
                r_valid <= 1'b0;
                r_done  <= 1'b0;
            end else if (bus.STALL) begin
                r_done  <= r_done | r_valid;
            end else begin
                r_valid     <= bus.MEM_VALID;
                r_reg_write <= bus.MEM_REG_WRITE;
                r_rd        <= bus.MEM_RD;
                r_result    <= w_result;
                r_done      <= 1'b0;
            end
        end
    end

    assign bus.WRITE        = w_write;
    assign bus.WRITE_REG    = r_rd;
    assign bus.WRITE_DATA   = r_result;
    assign bus.RETIRE_COUNT = r_retire_cnt;

`ifdef WB_BYPASS_EN
    logic             r_h1_valid;
    logic [4:0]       r_h1_rd;
    logic [XLEN-1:0]  r_h1_data;
    logic [XLEN:0]    w_fwd1;
    logic [XLEN:0]    w_fwd2;

    // H1 covers the write the register file commits at the next negedge,
    // which its registered read port has already missed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_h1_valid <= 1'b0;
            r_h1_rd    <= '0;
            r_h1_data  <= '0;
        end else begin
            r_h1_valid <= w_write;
            if (w_write) begin
                r_h1_rd   <= r_rd;
                r_h1_data <= r_result;
            end
        end
    end

    function automatic logic [XLEN:0] lookup(
        input logic [4:0]      rs,
        input logic            s_valid,
        input logic            s_regw,
        input logic [4:0]      s_rd,
        input logic [XLEN-1:0] s_data,
        input logic            h_valid,
        input logic [4:0]      h_rd,
        input logic [XLEN-1:0] h_data
    );
        if (rs == 5'd0)                            return '0;
        if (s_valid && s_regw && (s_rd == rs))     return {1'b1, s_data};
        if (h_valid && (h_rd == rs))               return {1'b1, h_data};
        return '0;
    endfunction

    always_comb begin
        w_fwd1 = lookup(bus.FWD_RS1, r_valid, r_reg_write, r_rd, r_result, r_h1_valid, r_h1_rd, r_h1_data);
        w_fwd2 = lookup(bus.FWD_RS2, r_valid, r_reg_write, r_rd, r_result, r_h1_valid, r_h1_rd, r_h1_data);
    end

    assign bus.FWD_RS1_HIT  = w_fwd1[XLEN];
    assign bus.FWD_RS1_DATA = w_fwd1[XLEN-1:0];
    assign bus.FWD_RS2_HIT  = w_fwd2[XLEN];
    assign bus.FWD_RS2_DATA = w_fwd2[XLEN-1:0];
`else
    logic w_unused_fwd;

    // without the history the hazard unit stalls, so the lookup reports no hits
    assign w_unused_fwd     = ^{bus.FWD_RS1, bus.FWD_RS2};
    assign bus.FWD_RS1_HIT  = 1'b0;
    assign bus.FWD_RS1_DATA = '0;
    assign bus.FWD_RS2_HIT  = 1'b0;
    assign bus.FWD_RS2_DATA = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage (CNT_W=4): directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_mem_wb_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mem_wb_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    mem_wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;

    // Model: the instruction sitting in the stage, the write performed last cycle, retirements
    bit               m_valid, m_regw, m_done, m_hv;
    logic [4:0]       m_rd, m_hrd;
    logic [31:0]      m_data, m_hdata;
    logic [CNT_W-1:0] m_count;

    function automatic logic [31:0] model_result(input logic [1:0] sel, input logic [2:0] f3,
                                                 input logic [31:0] addr, input logic [31:0] ld,
                                                 input logic [31:0] pc4);
        logic [31:0] b, h;
        if (sel == 2'b10) return pc4;
        if (sel != 2'b01) return addr;
        b = (ld >> (8 * addr[1:0])) & 32'hFF;
        h = (ld >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return ld;
        endcase
    endfunction

    function automatic bit exp_write();
        return m_valid && m_regw && (m_rd != 5'd0) && !m_done;
    endfunction

    function automatic logic [32:0] exp_fwd(input logic [4:0] rs);
        if (!BYP || rs == 5'd0) return '0;
        if (m_valid && m_regw && m_rd == rs) return {1'b1, m_data};
        if (m_hv && m_hrd == rs) return {1'b1, m_hdata};
        return '0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_regw = 1'b0; m_done = 1'b0; m_hv = 1'b0;
        m_rd = '0; m_hrd = '0; m_data = '0; m_hdata = '0; m_count = '0;
    endtask

    task automatic drive(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc4, input bit st, input bit fl);
        bus.MEM_VALID = v; bus.MEM_REG_WRITE = rw; bus.MEM_RD = rd; bus.MEM_WB_SEL = sel;
        bus.MEM_FUNCT3 = f3; bus.MEM_ALU_RESULT = alu; bus.MEM_LOAD_DATA = ld;
        bus.MEM_PC_PLUS4 = pc4; bus.STALL = st; bus.FLUSH = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // Advance one clock; the model takes the same edge using the driven inputs
    task automatic tick();
        bit wr;
        @(posedge CLK);
        if (RST_N) begin
            wr = exp_write();
            if (m_valid && !m_done) m_count = m_count + 1'b1;
            m_hv = wr; m_hrd = m_rd; m_hdata = m_data;
            if (bus.FLUSH) begin
                m_valid = 1'b0; m_done = 1'b0;
            end else if (bus.STALL) begin
                if (m_valid) m_done = 1'b1;
            end else begin
                m_valid = bus.MEM_VALID; m_regw = bus.MEM_REG_WRITE; m_rd = bus.MEM_RD;
                m_data = model_result(bus.MEM_WB_SEL, bus.MEM_FUNCT3, bus.MEM_ALU_RESULT,
                                      bus.MEM_LOAD_DATA, bus.MEM_PC_PLUS4);
                m_done = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        idle();
        bus.FWD_RS1 = 5'd0; bus.FWD_RS2 = 5'd0;
        RST_N = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        bus.FWD_RS1 = 5'd3; bus.FWD_RS2 = 5'd7;
        RST_N = 1'b0;
        model_reset();
        #2;
        n_cmp++; if (bus.WRITE !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %0b want 0", bus.WRITE); end
        n_cmp++; if (bus.WRITE_REG !== 5'd0) begin n_fail++; $display("FAIL reset_wreg: got %0d want 0", bus.WRITE_REG); end
        n_cmp++; if (bus.WRITE_DATA !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.WRITE_DATA); end
        n_cmp++; if (bus.RETIRE_COUNT !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.RETIRE_COUNT); end
        n_cmp++; if ({bus.FWD_RS1_HIT, bus.FWD_RS2_HIT} !== 2'b00) begin n_fail++; $display("FAIL reset_hit: got %b want 00", {bus.FWD_RS1_HIT, bus.FWD_RS2_HIT}); end
        n_cmp++; if ({bus.FWD_RS1_DATA, bus.FWD_RS2_DATA} !== 64'd0) begin n_fail++; $display("FAIL reset_fdata: got %h %h want 0", bus.FWD_RS1_DATA, bus.FWD_RS2_DATA); end
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_load_ext();
        logic [31:0] want [5];
        logic [2:0]  f3s  [5];
        logic [31:0] adr  [5];
        want = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_1234, 32'h80FF_1234};
        f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
        adr  = '{32'h3, 32'h3, 32'h2, 32'h1, 32'h0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 5'd9, 2'b01, f3s[i], adr[i], 32'h80FF_1234, 32'h0, 1'b0, 1'b0);
            tick();
            n_cmp++; if (bus.WRITE_DATA !== want[i]) begin n_fail++; $display("FAIL load_ext[%0d]: got %h want %h", i, bus.WRITE_DATA, want[i]); end
        end
        idle();
        tick();
    endtask

    task automatic test_source_select();
        logic [CNT_W-1:0] c0;
        drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b0, 32'hDEAD_0000, 32'h5555_5555, 32'h104, 1'b0, 1'b0);
        tick();
        n_cmp++; if ({bus.WRITE, bus.WRITE_REG, bus.WRITE_DATA} !== {1'b1, 5'd1, 32'h104}) begin
            n_fail++; $display("FAIL pc4_select: got %0b/%0d/%h want 1/1/104", bus.WRITE, bus.WRITE_REG, bus.WRITE_DATA); end
        drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b0, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        c0 = m_count;
        n_cmp++; if (bus.WRITE !== 1'b0) begin n_fail++; $display("FAIL rd0_write: got %0b want 0", bus.WRITE); end
        idle();
        tick();
        n_cmp++; if (bus.RETIRE_COUNT !== c0 + 1'b1) begin n_fail++; $display("FAIL rd0_retire: got %0d want %0d", bus.RETIRE_COUNT, c0 + 1'b1); end
    endtask

    task automatic test_stall();
        int pulses = 0;
        logic [CNT_W-1:0] c0;
        idle();
        tick();
        c0 = m_count;
        drive(1'b1, 1'b1, 5'd12, 2'b00, 3'b0, 32'hCAFE_0001, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        if (bus.WRITE === 1'b1) pulses++;
        drive(1'b0, 1'b0, 5'd4, 2'b00, 3'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            if (bus.WRITE === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
        n_cmp++; if (bus.RETIRE_COUNT !== c0 + 1'b1) begin n_fail++; $display("FAIL stall_retire: got %0d want %0d", bus.RETIRE_COUNT, c0 + 1'b1); end
        n_cmp++; if (bus.WRITE_DATA !== 32'hCAFE_0001) begin n_fail++; $display("FAIL stall_hold: got %h want cafe0001", bus.WRITE_DATA); end
        drive(1'b1, 1'b1, 5'd13, 2'b00, 3'b0, 32'h77, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        n_cmp++; if (bus.WRITE !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b want 0", bus.WRITE); end
        idle();
        tick();
    endtask

    task automatic test_bypass();
        logic [32:0] r1, r2;
        bus.FWD_RS1 = 5'd5; bus.FWD_RS2 = 5'd0;
        drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b0, 32'hA, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        r1 = BYP ? {1'b1, 32'hA} : 33'd0;
        n_cmp++; if ({bus.FWD_RS1_HIT, bus.FWD_RS1_DATA} !== r1) begin n_fail++; $display("FAIL byp_first: got %0b/%h want %0b/%h", bus.FWD_RS1_HIT, bus.FWD_RS1_DATA, r1[32], r1[31:0]); end
        drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b0, 32'hB, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        r1 = BYP ? {1'b1, 32'hB} : 33'd0;
        n_cmp++; if ({bus.FWD_RS1_HIT, bus.FWD_RS1_DATA} !== r1) begin n_fail++; $display("FAIL byp_stage_wins: got %0b/%h want %0b/%h", bus.FWD_RS1_HIT, bus.FWD_RS1_DATA, r1[32], r1[31:0]); end
        idle();
        tick();
        n_cmp++; if ({bus.FWD_RS1_HIT, bus.FWD_RS1_DATA} !== r1) begin n_fail++; $display("FAIL byp_h1: got %0b/%h want %0b/%h", bus.FWD_RS1_HIT, bus.FWD_RS1_DATA, r1[32], r1[31:0]); end
        r2 = 33'd0;
        n_cmp++; if ({bus.FWD_RS2_HIT, bus.FWD_RS2_DATA} !== r2) begin n_fail++; $display("FAIL byp_x0: got %0b/%h want 0/0", bus.FWD_RS2_HIT, bus.FWD_RS2_DATA); end
        tick();
        n_cmp++; if (bus.FWD_RS1_HIT !== 1'b0) begin n_fail++; $display("FAIL byp_aged: got %0b want 0", bus.FWD_RS1_HIT); end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b0, 32'h600D, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b0, 32'h600E, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.FWD_RS1 = 5'd6;
        tick();
        n_cmp++; if (bus.WRITE !== 1'b1) begin n_fail++; $display("FAIL midflight_pre: got %0b want 1", bus.WRITE); end
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({bus.WRITE, bus.FWD_RS1_HIT} !== 2'b00) begin n_fail++; $display("FAIL midflight_drop: got %b want 00", {bus.WRITE, bus.FWD_RS1_HIT}); end
        n_cmp++; if (bus.RETIRE_COUNT !== '0) begin n_fail++; $display("FAIL midflight_count: got %0d want 0", bus.RETIRE_COUNT); end
        idle();
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        n_cmp++; if ({bus.WRITE, bus.FWD_RS1_HIT} !== 2'b00) begin n_fail++; $display("FAIL midflight_after: got %b want 00", {bus.WRITE, bus.FWD_RS1_HIT}); end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, i[0], 5'(i), 2'b00, 3'b0, 32'(i), 32'h0, 32'h0, 1'b0, 1'b0);
            tick();
        end
        idle();
        tick();
        n_cmp++; if (bus.RETIRE_COUNT !== 4'd1) begin n_fail++; $display("FAIL wrap: got %0d want 1", bus.RETIRE_COUNT); end
    endtask

    task automatic test_random();
        logic [32:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            bus.FWD_RS1 = 5'($urandom_range(0, 7));
            bus.FWD_RS2 = 5'($urandom_range(0, 7));
            tick();
            e1 = exp_fwd(bus.FWD_RS1);
            e2 = exp_fwd(bus.FWD_RS2);
            n_cmp++; if (bus.WRITE !== exp_write()) begin n_fail++; $display("FAIL rnd_write[%0d]: got %0b want %0b", n, bus.WRITE, exp_write()); end
            if (m_valid) begin
                n_cmp++; if ({bus.WRITE_REG, bus.WRITE_DATA} !== {m_rd, m_data}) begin n_fail++; $display("FAIL rnd_wbus[%0d]: got %0d/%h want %0d/%h", n, bus.WRITE_REG, bus.WRITE_DATA, m_rd, m_data); end
            end
            n_cmp++; if ({bus.FWD_RS1_HIT, bus.FWD_RS1_DATA} !== e1) begin n_fail++; $display("FAIL rnd_fwd1[%0d]: got %0b/%h want %0b/%h", n, bus.FWD_RS1_HIT, bus.FWD_RS1_DATA, e1[32], e1[31:0]); end
            n_cmp++; if ({bus.FWD_RS2_HIT, bus.FWD_RS2_DATA} !== e2) begin n_fail++; $display("FAIL rnd_fwd2[%0d]: got %0b/%h want %0b/%h", n, bus.FWD_RS2_HIT, bus.FWD_RS2_DATA, e2[32], e2[31:0]); end
            n_cmp++; if (bus.RETIRE_COUNT !== m_count) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, bus.RETIRE_COUNT, m_count); end
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_source_select();
        test_stall();
        test_bypass();
        test_reset_midflight();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
